// File: rtl/sha3_seq_pkg.sv
// Shared types and helpers for the SHA3 scan sequencer: result status, FSM states,
// header sizing and hash width.
package sha3_seq_pkg;

  localparam int HASH_WORDS = 25;

  typedef enum logic [1:0] {
    FOUND     = 2'd0,
    EXHAUSTED = 2'd1,
    ABORTED   = 2'd2
  } seq_status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ACK    = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
  } seq_state_e;

  function automatic int INPUT_ELEMENTS(input int proper);
    return (proper != 0) ? 20 : 24;
  endfunction

endpackage

// File: rtl/sha3_seq_range_step.sv
// Computes the next chunk base and whether the nonce range is used up.
// The 33-bit sum catches wrap past 32'hFFFF_FFFF so a range never restarts at zero.
module sha3_seq_range_step (
  input  logic [31:0] i_base,
  input  logic [31:0] i_scan_count,
  input  logic [31:0] i_last,
  output logic [31:0] o_next,
  output logic        o_done
);

  logic [32:0] w_sum;

  always_comb begin
    w_sum  = {1'b0, i_base} + {1'b0, i_scan_count};
    o_next = w_sum[31:0];
    o_done = w_sum[32] | (w_sum[31:0] > i_last);
  end

endmodule

// File: rtl/sha3_scan_sequencer.sv
// Job-level controller that walks a nonce range chunk by chunk through the scanner.
// Optional perf counters (perf_cycles, perf_evals, sc_evaluating) under SHA3_SEQ_PERF_COUNTERS_EN.
module sha3_scan_sequencer
  import sha3_seq_pkg::*;
#(
  parameter  int PROPER      = 1,
  parameter  int NONCE_INDEX = 19,
  localparam int IE          = INPUT_ELEMENTS(PROPER)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [IE-1:0][31:0]          job_blobby,
  input  logic [63:0]                  job_threshold,
  input  logic [31:0]                  job_first,
  input  logic [31:0]                  job_last,
  input  logic                         abort,
  output logic                         sc_start,
  output logic [IE-1:0][31:0]          sc_blobby,
  output logic [63:0]                  sc_threshold,
  input  logic                         sc_idle,
  input  logic                         sc_found,
  input  logic [31:0]                  sc_nonce,
  input  logic [HASH_WORDS-1:0][63:0]  sc_hash,
  input  logic [31:0]                  sc_scan_count,
  output logic                         res_valid,
  input  logic                         res_ready,
  output seq_status_e                  res_status,
  output logic [31:0]                  res_nonce,
  output logic [HASH_WORDS-1:0][63:0]  res_hash,
  output logic [31:0]                  res_chunks
`ifdef SHA3_SEQ_PERF_COUNTERS_EN
  ,
  input  logic                         sc_evaluating,
  output logic [47:0]                  perf_cycles,
  output logic [47:0]                  perf_evals
`endif
);

  seq_state_e                 r_state;
  seq_state_e                 w_next_state;
  logic [IE-1:0][31:0]        r_blobby;
  logic [63:0]                r_threshold;
  logic [31:0]                r_base;
  logic [31:0]                r_last;
  logic [31:0]                r_chunks;
  seq_status_e                r_status;
  logic [31:0]                r_nonce;
  logic [HASH_WORDS-1:0][63:0] r_hash;
  logic                       w_accept;
  logic                       w_strobe;
  logic [31:0]                w_next_base;
  logic                       w_done;

  sha3_seq_range_step u_range_step (
    .i_base       (r_base),
    .i_scan_count (sc_scan_count),
    .i_last       (r_last),
    .o_next       (w_next_base),
    .o_done       (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Abort seen before the strobe ends the job without ever starting the scanner.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_strobe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (job_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (abort) begin
          w_next_state = S_REPORT;
        end else if (sc_idle) begin
          w_strobe     = 1'b1;
          w_next_state = S_ACK;
        end
      end
      S_ACK: begin
        if (!sc_idle) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (sc_idle) begin
          if (sc_found || abort || w_done) w_next_state = S_REPORT;
          else                             w_next_state = S_START;
        end
      end
      S_REPORT: begin
        if (res_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blobby    <= '0;
      r_threshold <= '0;
      r_base      <= '0;
      r_last      <= '0;
      r_chunks    <= '0;
      r_status    <= FOUND;
      r_nonce     <= '0;
      r_hash      <= '0;
    end else begin
      if (w_accept) begin
        r_blobby    <= job_blobby;
        r_threshold <= job_threshold;
        r_base      <= job_first;
        r_last      <= job_last;
        r_chunks    <= '0;
        r_status    <= FOUND;
        r_nonce     <= '0;
        r_hash      <= '0;
      end
      if (r_state == S_START && abort) r_status <= ABORTED;
      if (w_strobe) r_chunks <= r_chunks + 32'd1;
      // Found outranks abort, which outranks range exhaustion.
      if (r_state == S_RUN && sc_idle) begin
        if (sc_found) begin
          r_status <= FOUND;
          r_nonce  <= sc_nonce;
          r_hash   <= sc_hash;
        end else if (abort) begin
          r_status <= ABORTED;
        end else if (w_done) begin
          r_status <= EXHAUSTED;
        end else begin
          r_base <= w_next_base;
        end
      end
    end
  end

  always_comb begin
    sc_blobby              = r_blobby;
    sc_blobby[NONCE_INDEX] = r_base;
  end

  assign job_ready    = (r_state == S_IDLE);
  assign sc_start     = w_strobe;
  assign sc_threshold = r_threshold;
  assign res_valid    = (r_state == S_REPORT);
  assign res_status   = r_status;
  assign res_nonce    = r_nonce;
  assign res_hash     = r_hash;
  assign res_chunks   = r_chunks;

`ifdef SHA3_SEQ_PERF_COUNTERS_EN
  logic [47:0] r_perf_cycles;
  logic [47:0] r_perf_evals;
  logic        w_active;

  assign w_active = (r_state != S_IDLE) && (r_state != S_REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_evals  <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_evals  <= '0;
    end else if (w_active) begin
      r_perf_cycles <= r_perf_cycles + 48'd1;
      if (sc_evaluating) r_perf_evals <= r_perf_evals + 48'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_evals  = r_perf_evals;
`endif

endmodule

// File: tb/tb_sha3_scan_sequencer.sv
// Bench for sha3_scan_sequencer: a behavioural scanner plus a range-walk reference model,
// directed corner jobs followed by randomized jobs.
module tb_sha3_scan_sequencer;
  import sha3_seq_pkg::*;

  localparam int IE = 20;
  localparam int NI = 19;
  localparam int HW = HASH_WORDS;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  job_valid = 1'b0;
  logic                  job_ready;
  logic [IE-1:0][31:0]   job_blobby = '0;
  logic [63:0]           job_threshold = '0;
  logic [31:0]           job_first = '0;
  logic [31:0]           job_last = '0;
  logic                  abort;
  logic                  sc_start;
  logic [IE-1:0][31:0]   sc_blobby;
  logic [63:0]           sc_threshold;
  logic                  sc_idle = 1'b1;
  logic                  sc_found = 1'b0;
  logic [31:0]           sc_nonce = '0;
  logic [HW-1:0][63:0]   sc_hash = '0;
  logic [31:0]           sc_scan_count = 32'd16;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  seq_status_e           res_status;
  logic [31:0]           res_nonce;
  logic [HW-1:0][63:0]   res_hash;
  logic [31:0]           res_chunks;
`ifdef SHA3_SEQ_PERF_COUNTERS_EN
  logic [47:0]           perf_cycles;
  logic [47:0]           perf_evals;
`endif

  always #5 clk = ~clk;

  sha3_scan_sequencer #(.PROPER(1), .NONCE_INDEX(NI)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_blobby(job_blobby),
    .job_threshold(job_threshold), .job_first(job_first), .job_last(job_last),
    .abort(abort), .sc_start(sc_start), .sc_blobby(sc_blobby), .sc_threshold(sc_threshold),
    .sc_idle(sc_idle), .sc_found(sc_found), .sc_nonce(sc_nonce), .sc_hash(sc_hash),
    .sc_scan_count(sc_scan_count), .res_valid(res_valid), .res_ready(res_ready),
    .res_status(res_status), .res_nonce(res_nonce), .res_hash(res_hash), .res_chunks(res_chunks)
`ifdef SHA3_SEQ_PERF_COUNTERS_EN
    , .sc_evaluating(~sc_idle), .perf_cycles(perf_cycles), .perf_evals(perf_evals)
`endif
  );

  int            n_asserts = 0;
  int            n_fails = 0;
  logic          abort_en = 1'b0;
  int            abort_chunk = 0;
  int            find_chunk = 0;
  logic [31:0]   find_off = '0;
  int            lat = 3;
  int            tot = 0;
  int            job_base_cnt = 0;
  int            busy = 0;
  logic [31:0]   cur_base = '0;
  logic [31:0]   base_log[$];
  logic [31:0]   exp_bases[$];
  seq_status_e   exp_status;
  int            exp_chunks;
  logic [31:0]   exp_nonce;

  assign abort = abort_en && ((tot - job_base_cnt) >= abort_chunk);

  function automatic logic [HW-1:0][63:0] mk_hash(input logic [31:0] n);
    logic [HW-1:0][63:0] h;
    for (int i = 0; i < HW; i++) h[i] = {n, 32'(i) ^ 32'hA5A5_0000};
    return h;
  endfunction

  // Behavioural scanner: latches a strobe, stays busy lat cycles, then reports.
  always @(posedge clk) begin
    if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        sc_idle <= 1'b1;
        if ((tot - job_base_cnt) == find_chunk) begin
          sc_found <= 1'b1;
          sc_nonce <= cur_base + find_off;
          sc_hash  <= mk_hash(cur_base + find_off);
        end
      end
    end else if (sc_start && sc_idle) begin
      sc_idle  <= 1'b0;
      sc_found <= 1'b0;
      sc_nonce <= '0;
      busy     <= lat;
      tot      <= tot + 1;
      cur_base <= sc_blobby[NI];
      base_log.push_back(sc_blobby[NI]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Range walk from first in scan-count steps, stopping on find, abort or overrun.
  task automatic ref_model(input logic [31:0] first, input logic [31:0] last,
                           input logic [31:0] sc, input int fc, input logic [31:0] foff,
                           input logic aen, input int ac);
    longint unsigned b;
    exp_bases.delete();
    exp_chunks = 0;
    exp_nonce  = '0;
    exp_status = EXHAUSTED;
    if (aen && ac == 0) begin
      exp_status = ABORTED;
      return;
    end
    b = 64'(first);
    for (int guard = 0; guard < 1000; guard++) begin
      exp_bases.push_back(b[31:0]);
      exp_chunks++;
      if (exp_chunks == fc) begin
        exp_status = FOUND;
        exp_nonce  = b[31:0] + foff;
        return;
      end
      if (aen && exp_chunks >= ac) begin
        exp_status = ABORTED;
        return;
      end
      if (b + 64'(sc) > 64'(last)) begin
        exp_status = EXHAUSTED;
        return;
      end
      b = b + 64'(sc);
    end
  endtask

  task automatic run_job(input logic [31:0] first, input logic [31:0] last, input logic [31:0] sc,
                         input int fc, input logic [31:0] foff, input logic aen, input int ac,
                         input int l, input int rdelay);
    int          cnt;
    int          start_log;
    logic [31:0] blob0;
    logic [63:0] thr;
    logic [HW-1:0][63:0] exp_hash;
    ref_model(first, last, sc, fc, foff, aen, ac);
    @(negedge clk);
    for (int i = 0; i < IE; i++) job_blobby[i] = $urandom;
    blob0         = job_blobby[0];
    thr           = {$urandom, $urandom};
    job_threshold = thr;
    job_first     = first;
    job_last      = last;
    sc_scan_count = sc;
    lat           = l;
    find_chunk    = fc;
    find_off      = foff;
    abort_chunk   = ac;
    job_base_cnt  = tot;
    start_log     = base_log.size();
    abort_en      = aen;
    job_valid     = 1'b1;
    cnt = 0;
    while (!job_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_timeout", 64'(job_ready), 64'd1);
    @(negedge clk);
    job_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk("result_timeout", 64'(res_valid), 64'd1);
    exp_hash = (exp_status == FOUND) ? mk_hash(exp_nonce) : '0;
    chk("status", 64'(res_status), 64'(exp_status));
    chk("chunks", 64'(res_chunks), 64'(exp_chunks));
    chk("nonce", 64'(res_nonce), 64'(exp_nonce));
    chk("hash", 64'(res_hash === exp_hash), 64'd1);
    chk("threshold", sc_threshold, thr);
    chk("blobby0", 64'(sc_blobby[0]), 64'(blob0));
    chk("strobes", 64'(base_log.size() - start_log), 64'(exp_bases.size()));
    for (int i = 0; i < exp_bases.size() && start_log + i < base_log.size(); i++)
      chk("chunk_base", 64'(base_log[start_log + i]), 64'(exp_bases[i]));
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_job_ready", 64'(job_ready), 64'd0);
      chk("hold_chunks", 64'(res_chunks), 64'(exp_chunks));
      chk("hold_status", 64'(res_status), 64'(exp_status));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("job_ready_after", 64'(job_ready), 64'd1);
    chk("res_valid_after", 64'(res_valid), 64'd0);
    @(negedge clk);
    res_ready = 1'b0;
    abort_en  = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] f, s;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", 64'(job_ready), 64'd1);
    chk("rst_sc_start", 64'(sc_start), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_chunks", 64'(res_chunks), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(32'd0, 32'd63, 32'd16, 0, 32'd0, 1'b0, 0, 3, 0);
    run_job(32'd0, 32'd63, 32'd16, 3, 32'd5, 1'b0, 0, 3, 0);
    run_job(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd32, 0, 32'd0, 1'b0, 0, 2, 0);
    run_job(32'd0, 32'd63, 32'd16, 0, 32'd0, 1'b1, 2, 3, 0);
    run_job(32'd0, 32'd63, 32'd16, 2, 32'd7, 1'b1, 2, 3, 0);
    run_job(32'd0, 32'd63, 32'd16, 0, 32'd0, 1'b1, 0, 3, 0);
    run_job(32'd100, 32'd50, 32'd16, 0, 32'd0, 1'b0, 0, 1, 0);
    run_job(32'd0, 32'd31, 32'd16, 0, 32'd0, 1'b0, 0, 2, 10);

    // Reset while a chunk is in flight.
    sc_scan_count = 32'd16;
    lat           = 20;
    find_chunk    = 0;
    job_first     = 32'd0;
    job_last      = 32'd1000;
    job_threshold = 64'h1234_5678_9ABC_DEF0;
    job_base_cnt  = tot;
    job_valid     = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    cnt = 0;
    while (!((tot - job_base_cnt) == 2 && !sc_idle) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_run_timeout", 64'(tot - job_base_cnt), 64'd2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_job_ready", 64'(job_ready), 64'd1);
    chk("mid_rst_sc_start", 64'(sc_start), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_chunks", 64'(res_chunks), 64'd0);
    chk("mid_rst_threshold", sc_threshold, 64'd0);
    chk("mid_rst_nonce", 64'(res_nonce), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!sc_idle && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("scanner_drain", 64'(sc_idle), 64'd1);
    run_job(32'd10, 32'd40, 32'd8, 2, 32'd3, 1'b0, 0, 2, 0);

    for (int j = 0; j < 10; j++) begin
      f = $urandom;
      if (j % 3 == 0) f = 32'hFFFF_FF00 | ($urandom & 32'hFF);
      s = $urandom_range(1, 16);
      run_job(f, f + $urandom_range(0, 80), s, int'($urandom_range(0, 5)),
              $urandom_range(0, 31) % s, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
